// File: rtl/demux1way4_buf.sv
// -----------------------------------------------------------------------------
// demux1way4_buf
//
// Buffered 1-to-4 demultiplexer. One WIDTH-bit word per accepted transfer is
// steered to one of four sink lanes selected by in_sel. Each lane owns a
// one-entry holding register with a valid/ready handshake. This lets
// independent consumers (regfile, PC, memory, HI/LO, ...) stall on their own
// without affecting the other lanes.
//
// Parameters
//   WIDTH      data word width in bits
//   CNT_W      width of the accepted-transfer counter (wraps silently)
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   in_data    word to route
//   in_sel     destination lane 0..3
//   in_valid   in_data/in_sel valid this cycle
//   in_ready   selected lane can take a word this cycle (combinational)
//   out_data   lane i occupies bits [i*WIDTH +: WIDTH] (registered)
//   out_valid  lane i holds an undelivered word (registered)
//   out_ready  sink i accepts its word this cycle
//   xfer_cnt   number of accepted input transfers, modulo 2^CNT_W
// -----------------------------------------------------------------------------
module demux1way4_buf #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     in_data,
    input  logic [1:0]           in_sel,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [4*WIDTH-1:0]   out_data,
    output logic [3:0]           out_valid,
    input  logic [3:0]           out_ready,
    output logic [CNT_W-1:0]     xfer_cnt
);

    localparam int unsigned LANES = 4;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } lane_state_t;

    lane_state_t        r_state [LANES];
    logic [WIDTH-1:0]   r_data  [LANES];
    logic [CNT_W-1:0]   r_cnt;

    logic               w_sel_full;
    logic               w_accept;
    logic [LANES-1:0]   w_load;
    logic [LANES-1:0]   w_drain;

    // A full lane can still take a word if its sink is draining this cycle;
    // that makes refill-while-draining bubble-free.
    always_comb begin
        w_sel_full = (r_state[in_sel] == FULL);
        in_ready   = ~w_sel_full | out_ready[in_sel];
        w_accept   = in_valid & in_ready;
    end

    always_comb begin
        w_load  = '0;
        w_drain = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            w_load[i]  = w_accept && (in_sel == 2'(i));
            w_drain[i] = (r_state[i] == FULL) && out_ready[i];
        end
    end

    // Per-lane EMPTY/FULL state machine. A load takes priority over a drain,
    // so a simultaneous drain+load stays FULL with the new word.
    // Data is never cleared on drain: stale words remain visible and sinks
    // must qualify them with out_valid.
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_state[g] <= EMPTY;
                r_data[g]  <= '0;
            end else begin
                case (r_state[g])
                    EMPTY: begin
                        if (w_load[g]) begin
                            r_state[g] <= FULL;
                            r_data[g]  <= in_data;
                        end
                    end
                    FULL: begin
                        if (w_load[g]) begin
                            r_data[g]  <= in_data;
                        end else if (w_drain[g]) begin
                            r_state[g] <= EMPTY;
                        end
                    end
                    default: begin
                        r_state[g] <= EMPTY;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_comb begin
        out_data  = '0;
        out_valid = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            out_valid[i]               = (r_state[i] == FULL);
            out_data[i*WIDTH +: WIDTH] = r_data[i];
        end
    end

    assign xfer_cnt = r_cnt;

endmodule

// File: tb/tb_demux1way4_buf.sv
// -----------------------------------------------------------------------------
// tb_demux1way4_buf
//
// Directed self-checking bench for demux1way4_buf. Inputs are driven 1 time
// unit after each rising edge; outputs are sampled at the same point, i.e.
// after registered values have settled and away from the active edge.
// -----------------------------------------------------------------------------
module tb_demux1way4_buf;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned CNT_W = 16;

    logic                 clk;
    logic                 reset;
    logic [WIDTH-1:0]     in_data;
    logic [1:0]           in_sel;
    logic                 in_valid;
    logic                 in_ready;
    logic [4*WIDTH-1:0]   out_data;
    logic [3:0]           out_valid;
    logic [3:0]           out_ready;
    logic [CNT_W-1:0]     xfer_cnt;

    int unsigned n_checks;
    int unsigned n_fail;

    demux1way4_buf #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .xfer_cnt  (xfer_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        if (out_valid !== 4'b0000) begin
            n_fail++; $display("FAIL reset_valid: got %b expected 0000", out_valid);
        end
        n_checks++;
        if (out_data !== '0) begin
            n_fail++; $display("FAIL reset_data: got %h expected 0", out_data);
        end
        n_checks++;
        if (xfer_cnt !== 16'd0) begin
            n_fail++; $display("FAIL reset_cnt: got %0d expected 0", xfer_cnt);
        end
        n_checks++;
        for (int s = 0; s < 4; s++) begin
            in_sel = 2'(s);
            #1;
            if (in_ready !== 1'b1) begin
                n_fail++; $display("FAIL reset_ready sel=%0d: got %b expected 1", s, in_ready);
            end
            n_checks++;
        end
    endtask

    task automatic test_single_route();
        out_ready = 4'b0000;
        in_sel    = 2'd2;
        in_data   = 32'hA5A5A5A5;
        in_valid  = 1'b1;
        step();
        in_valid  = 1'b0;
        in_data   = 32'h0;
        if (out_valid !== 4'b0100) begin
            n_fail++; $display("FAIL route_valid: got %b expected 0100", out_valid);
        end
        n_checks++;
        if (out_data !== {32'h0, 32'hA5A5A5A5, 64'h0}) begin
            n_fail++; $display("FAIL route_data: got %h expected lane2=a5a5a5a5 others 0", out_data);
        end
        n_checks++;
        if (xfer_cnt !== 16'd1) begin
            n_fail++; $display("FAIL route_cnt: got %0d expected 1", xfer_cnt);
        end
        n_checks++;
        in_sel = 2'd2;
        #1;
        if (in_ready !== 1'b0) begin
            n_fail++; $display("FAIL route_ready_full: got %b expected 0", in_ready);
        end
        n_checks++;
        in_sel = 2'd0;
        #1;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL route_ready_empty: got %b expected 1", in_ready);
        end
        n_checks++;
        // Stalled lane: a valid word to a full, non-draining lane is not taken.
        in_sel   = 2'd2;
        in_data  = 32'hDEADBEEF;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        if (out_data[2*WIDTH +: WIDTH] !== 32'hA5A5A5A5 || out_valid !== 4'b0100) begin
            n_fail++; $display("FAIL stall_hold: got lane2=%h valid=%b expected a5a5a5a5 0100",
                               out_data[2*WIDTH +: WIDTH], out_valid);
        end
        n_checks++;
        if (xfer_cnt !== 16'd1) begin
            n_fail++; $display("FAIL stall_cnt: got %0d expected 1", xfer_cnt);
        end
        n_checks++;
    endtask

    task automatic test_refill();
        out_ready = 4'b0100;
        in_sel    = 2'd2;
        in_data   = 32'h00001234;
        in_valid  = 1'b1;
        #1;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL refill_ready: got %b expected 1", in_ready);
        end
        n_checks++;
        step();
        in_valid  = 1'b0;
        out_ready = 4'b0000;
        if (out_valid !== 4'b0100) begin
            n_fail++; $display("FAIL refill_valid: got %b expected 0100", out_valid);
        end
        n_checks++;
        if (out_data[2*WIDTH +: WIDTH] !== 32'h00001234) begin
            n_fail++; $display("FAIL refill_data: got %h expected 00001234", out_data[2*WIDTH +: WIDTH]);
        end
        n_checks++;
        if (xfer_cnt !== 16'd2) begin
            n_fail++; $display("FAIL refill_cnt: got %0d expected 2", xfer_cnt);
        end
        n_checks++;
        out_ready = 4'b0100;
        step();
        out_ready = 4'b0000;
        if (out_valid !== 4'b0000) begin
            n_fail++; $display("FAIL refill_drain: got %b expected 0000", out_valid);
        end
        n_checks++;
        if (out_data[2*WIDTH +: WIDTH] !== 32'h00001234) begin
            n_fail++; $display("FAIL stale_data: got %h expected 00001234", out_data[2*WIDTH +: WIDTH]);
        end
        n_checks++;
    endtask

    task automatic test_sweep();
        logic [3:0] exp_v;
        out_ready = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            in_sel   = 2'(k);
            in_data  = 32'(k + 1);
            in_valid = 1'b1;
            #1;
            if (in_ready !== 1'b1) begin
                n_fail++; $display("FAIL sweep_ready k=%0d: got %b expected 1", k, in_ready);
            end
            n_checks++;
            step();
            exp_v = 4'b0001 << k;
            if (out_valid !== exp_v) begin
                n_fail++; $display("FAIL sweep_valid k=%0d: got %b expected %b", k, out_valid, exp_v);
            end
            n_checks++;
            if (out_data[k*WIDTH +: WIDTH] !== 32'(k + 1)) begin
                n_fail++; $display("FAIL sweep_data k=%0d: got %h expected %h",
                                   k, out_data[k*WIDTH +: WIDTH], 32'(k + 1));
            end
            n_checks++;
        end
        in_valid = 1'b0;
        step();
        out_ready = 4'b0000;
        if (out_valid !== 4'b0000) begin
            n_fail++; $display("FAIL sweep_end_valid: got %b expected 0000", out_valid);
        end
        n_checks++;
        if (xfer_cnt !== 16'd6) begin
            n_fail++; $display("FAIL sweep_cnt: got %0d expected 6", xfer_cnt);
        end
        n_checks++;
    endtask

    task automatic test_independence();
        out_ready = 4'b0000;
        in_sel    = 2'd3;
        in_data   = 32'h00000009;
        in_valid  = 1'b1;
        step();
        out_ready = 4'b1000;
        in_sel    = 2'd0;
        in_data   = 32'h00000007;
        in_valid  = 1'b1;
        step();
        in_valid  = 1'b0;
        out_ready = 4'b0000;
        if (out_valid !== 4'b0001) begin
            n_fail++; $display("FAIL indep_valid: got %b expected 0001", out_valid);
        end
        n_checks++;
        if (out_data[0 +: WIDTH] !== 32'h7 || out_data[3*WIDTH +: WIDTH] !== 32'h9) begin
            n_fail++; $display("FAIL indep_data: got lane0=%h lane3=%h expected 7 9",
                               out_data[0 +: WIDTH], out_data[3*WIDTH +: WIDTH]);
        end
        n_checks++;
        if (xfer_cnt !== 16'd8) begin
            n_fail++; $display("FAIL indep_cnt: got %0d expected 8", xfer_cnt);
        end
        n_checks++;
        out_ready = 4'b0001;
        step();
        out_ready = 4'b0000;
    endtask

    task automatic test_midop_reset();
        in_sel   = 2'd1;
        in_data  = 32'h00000055;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        if (out_valid !== 4'b0010) begin
            n_fail++; $display("FAIL midreset_pre: got %b expected 0010", out_valid);
        end
        n_checks++;
        #2;
        reset = 1'b1;
        #1;
        if (out_valid !== 4'b0000 || out_data !== '0 || xfer_cnt !== 16'd0) begin
            n_fail++; $display("FAIL midreset_async: got valid=%b cnt=%0d data=%h expected 0000 0 0",
                               out_valid, xfer_cnt, out_data);
        end
        n_checks++;
        step();
        reset = 1'b0;
    endtask

    task automatic test_wrap();
        out_ready = 4'b1111;
        in_valid  = 1'b1;
        for (int n = 0; n < 65535; n++) begin
            in_sel  = 2'(n);
            in_data = 32'(n);
            step();
        end
        if (xfer_cnt !== 16'hFFFF) begin
            n_fail++; $display("FAIL wrap_max: got %h expected ffff", xfer_cnt);
        end
        n_checks++;
        in_sel = 2'd3;
        step();
        in_valid = 1'b0;
        if (xfer_cnt !== 16'h0000) begin
            n_fail++; $display("FAIL wrap_zero: got %h expected 0000", xfer_cnt);
        end
        n_checks++;
        step();
        out_ready = 4'b0000;
        if (out_valid !== 4'b0000) begin
            n_fail++; $display("FAIL wrap_drained: got %b expected 0000", out_valid);
        end
        n_checks++;
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        reset     = 1'b1;
        in_data   = '0;
        in_sel    = '0;
        in_valid  = 1'b0;
        out_ready = '0;
        step();
        step();
        reset = 1'b0;
        test_reset();
        test_single_route();
        test_refill();
        test_sweep();
        test_independence();
        test_midop_reset();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
